mips_seq_ctrl: RTL
==================

# mips_seq_ctrl

Multi-cycle sequencer for the MIPS datapath. It fetches each instruction through a req/ack instruction-memory port, holds it in an instruction register that feeds the execute unit, and gates the register-file write to a single write-back cycle. It also runs the data-memory handshake and computes the next PC from jump, branch and ALU-zero results. It sits between instruction/data memory and the execute unit, and acts as the processor's top-level control FSM.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- TIMEOUT_CYCLES, 16, cycles a memory request may wait for ack (only with SEQ_TIMEOUT_EN)
- CLK  in  1  single clock, rising-edge state updates
- RST_N  in  1  asynchronous, active-low reset
- start  in  1  level; leaves IDLE
- imem_req / imem_addr  out  1/32  fetch request, address = pc
- imem_rdata / imem_ack  in  32/1  fetch data, valid when ack
- instr  out  32  instruction register, to execute unit
- branch, jump, mem_read, mem_write, reg_write, zero  in  1 each  decoded controls and ALU zero from the datapath
- imm32 / instr_index  in  32/26  extended immediate and jump target
- dmem_req / dmem_we  out  1/1  data request; we = mem_write
- dmem_ack  in  1  data access complete
- reg_we  out  1  gated register-file write enable
- pc  out  32  current PC
- state  out  3  FSM state encoding
- halted  out  1  HALT reached (or timeout error)
- retired  out  32  count of instructions completed

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
- **IDLE**: go to FETCH when start=1.
- **FETCH**: imem_req=1 and imem_addr=pc. On a rising edge with imem_ack=1, latch instr=imem_rdata, latch pc_plus4=pc+4, then go to DECODE.
- **DECODE**: one cycle. If instr[31:26]==6'b111111, go to HALT; otherwise go to EXEC.
- **EXEC**: one cycle. Latch take_branch = branch & zero. Go to MEM if mem_read|mem_write, otherwise go to WB.
- **MEM**: dmem_req=1 and dmem_we=mem_write. On dmem_ack=1, go to WB.
- **WB**: reg_we=reg_write, for exactly one cycle; the datapath writes on the falling edge inside this cycle. Update pc:
  - jump=1: pc = {pc_plus4[31:28], instr_index, 2'b00}
  - else take_branch=1: pc = pc_plus4 + (imm32<<2), 32-bit wrap
  - else: pc = pc_plus4
  - Then increment retired (32-bit wrap) and go to FETCH.
- **HALT**: terminal; halted=1. Exit only through reset; start is ignored.
- **Boundary cases**:
  - An ack arriving while its req is low is ignored.
  - An ack in the first req cycle is accepted.
  - jump takes priority over branch.
  - pc+4 wraps at 2^32.
- **Reset** (async, any state): state=IDLE, pc=RESET_PC, instr=0, pc_plus4=0, all req/we outputs 0, halted=0, retired=0. A memory transaction in progress is abandoned.

## Timing
- Instruction latency with zero-wait memories:
  - ALU op: FETCH1 + DECODE1 + EXEC1 + WB1 = 4 cycles
  - load/store: 5 cycles
- Each memory wait cycle adds one cycle.
- imem_req and dmem_req are Moore outputs; they drop in the cycle after the ack edge.
- reg_we is a Moore output, high only in WB.

## Configuration
- SEQ_TIMEOUT_EN defined:
  - A 16-bit wait counter clears on entry to FETCH or MEM.
  - If it reaches TIMEOUT_CYCLES without an ack, go to ERR: halted=1, all requests low, terminal until reset.
- SEQ_TIMEOUT_EN undefined: no counter, no ERR state; the FSM waits for ack forever.

## Structure
- Package mips_seq_pkg holds:
  - the state enum/localparams
  - OP_HALT=6'b111111
  - the PC width constant
- One sub-module, mips_pc_next: a combinational next-PC mux taking pc_plus4, imm32, instr_index, jump and take_branch.

## Test plan
- Reset, then start, with imem returning 0x20080005 (addi) and ack on the first cycle → WB reached 3 cycles after leaving FETCH; reg_we high 1 cycle; pc=0x4; retired=1.
- Fetch ack delayed 3 cycles → imem_req high 4 cycles; instr latched only on the ack edge.
- beq with zero=1 and imm32=0xFFFFFFFF at pc=0x10 → next pc=0x10.
- Jump at pc=0x40 with instr_index=0x0000100 → pc=0x400; branch inputs ignored.
- Load with dmem_ack after 2 cycles → MEM lasts 3 cycles; then instruction opcode 0x3F → HALT, halted=1, start ignored.
- RST_N asserted mid-MEM → immediate IDLE, dmem_req=0, pc=RESET_PC. With SEQ_TIMEOUT_EN and ack never given → ERR after 16 cycles.

Source files
------------

// File: rtl/mips_seq_pkg.sv
// Shared types and constants for the MIPS multi-cycle sequencer.
package mips_seq_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned INDEX_W = 26;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned WAIT_W  = 16;

    localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERR    = 3'd7
    } state_e;

endpackage

// File: rtl/mips_pc_next.sv
// Combinational next-PC select: jump target, taken branch, or sequential pc+4.
module mips_pc_next
    import mips_seq_pkg::*;
(
    input  logic [PC_W-1:0]    pc_plus4,
    input  logic [PC_W-1:0]    imm32,
    input  logic [INDEX_W-1:0] instr_index,
    input  logic               jump,
    input  logic               take_branch,
    output logic [PC_W-1:0]    pc_next_c
);

    // Jump wins over branch; branch offset is word-scaled and wraps at 2^32.
    always_comb begin
        pc_next_c = pc_plus4;
        if (jump) begin
            pc_next_c = {pc_plus4[PC_W-1:PC_W-4], instr_index, 2'b00};
        end else if (take_branch) begin
            pc_next_c = pc_plus4 + (imm32 << 2);
        end
    end

endmodule

// File: rtl/mips_seq_ctrl.sv
// Top-level multi-cycle control FSM: fetch, decode, execute, memory, write-back.
// Optional memory-ack timeout to an ERR state is built when SEQ_TIMEOUT_EN is defined.
module mips_seq_ctrl
    import mips_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
`ifdef SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    output logic [INSTR_W-1:0] instr,
    input  logic               branch,
    input  logic               jump,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic               reg_write,
    input  logic               zero,
    input  logic [PC_W-1:0]    imm32,
    input  logic [INDEX_W-1:0] instr_index,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ack,
    output logic               reg_we,
    output logic [PC_W-1:0]    pc,
    output logic [2:0]         state,
    output logic               halted,
    output logic [31:0]        retired
);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    pc_plus4_q, pc_plus4_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               take_branch_q, take_branch_d;
    logic [31:0]        retired_q, retired_d;
    logic               imem_req_q, imem_req_d;
    logic               dmem_req_q, dmem_req_d;
    logic               dmem_we_q, dmem_we_d;
    logic               reg_we_q, reg_we_d;
    logic               halted_q, halted_d;
    logic [PC_W-1:0]    pc_next_c;
`ifdef SEQ_TIMEOUT_EN
    logic [WAIT_W-1:0]  wait_q, wait_d;
`endif

    mips_pc_next u_pc_next (
        .pc_plus4    (pc_plus4_q),
        .imm32       (imm32),
        .instr_index (instr_index),
        .jump        (jump),
        .take_branch (take_branch_q),
        .pc_next_c   (pc_next_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            pc_plus4_q    <= '0;
            instr_q       <= '0;
            take_branch_q <= 1'b0;
            retired_q     <= '0;
            imem_req_q    <= 1'b0;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            reg_we_q      <= 1'b0;
            halted_q      <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            wait_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_plus4_q    <= pc_plus4_d;
            instr_q       <= instr_d;
            take_branch_q <= take_branch_d;
            retired_q     <= retired_d;
            imem_req_q    <= imem_req_d;
            dmem_req_q    <= dmem_req_d;
            dmem_we_q     <= dmem_we_d;
            reg_we_q      <= reg_we_d;
            halted_q      <= halted_d;
`ifdef SEQ_TIMEOUT_EN
            wait_q        <= wait_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_plus4_d    = pc_plus4_q;
        instr_d       = instr_q;
        take_branch_d = take_branch_q;
        retired_d     = retired_q;
`ifdef SEQ_TIMEOUT_EN
        wait_d        = wait_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d    = imem_rdata;
                    pc_plus4_d = pc_q + PC_W'(4);
                    state_d    = ST_DECODE;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) state_d = ST_ERR;
                else wait_d = wait_q + WAIT_W'(1);
`endif
            end
            ST_DECODE: begin
                state_d = (instr_q[INSTR_W-1:INSTR_W-OP_W] == OP_HALT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                take_branch_d = branch & zero;
                state_d       = (mem_read | mem_write) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (dmem_ack) state_d = ST_WB;
`ifdef SEQ_TIMEOUT_EN
                else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) state_d = ST_ERR;
                else wait_d = wait_q + WAIT_W'(1);
`endif
            end
            ST_WB: begin
                pc_d      = pc_next_c;
                retired_d = retired_q + 32'd1;
                state_d   = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
`ifdef SEQ_TIMEOUT_EN
            ST_ERR:  state_d = ST_ERR;
`endif
            default: state_d = ST_IDLE;
        endcase

`ifdef SEQ_TIMEOUT_EN
        // Fresh wait budget on every entry into a memory-wait state.
        if ((state_d != state_q) && (state_d == ST_FETCH || state_d == ST_MEM)) begin
            wait_d = '0;
        end
`endif

        // Moore outputs registered from the next state so they align with state_q.
        imem_req_d = (state_d == ST_FETCH);
        dmem_req_d = (state_d == ST_MEM);
        dmem_we_d  = (state_d == ST_MEM) & mem_write;
        reg_we_d   = (state_d == ST_WB) & reg_write;
        halted_d   = (state_d == ST_HALT) || (state_d == ST_ERR);
    end

    assign state     = state_q;
    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign retired   = retired_q;
    assign imem_req  = imem_req_q;
    assign dmem_req  = dmem_req_q;
    assign dmem_we   = dmem_we_q;
    assign reg_we    = reg_we_q;
    assign halted    = halted_q;

endmodule
